// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bus bundle between the control state machine / memory side and the
// instruction-fetch datapath.
//
// Parameters
//   AW : address width (PC, operand field, memory address)
//   DW : data bus width (instruction is 2*DW wide)
//
// Signals
//   data     : memory/bus read data              (controller -> fetch unit)
//   load_ir  : capture current instruction byte  (controller -> fetch unit)
//   inc_pc   : PC += 1                           (controller -> fetch unit)
//   load_pc  : PC <= operand address             (controller -> fetch unit)
//   halt     : latch halted state                (controller -> fetch unit)
//   fetch    : 1 = address from PC, 0 = from IR  (controller -> fetch unit)
//   opcode   : IR[15:13]                         (fetch unit -> controller)
//   ir_addr  : IR[12:0] operand address          (fetch unit -> controller)
//   pc_addr  : current PC                        (fetch unit -> controller)
//   addr     : memory address                    (fetch unit -> memory)
//   ir_valid : full instruction held in IR       (fetch unit -> controller)
//   halted   : sticky halt status                (fetch unit -> controller)
//   pc_fault : PC overflow flag                  (fetch unit -> controller)
//
// Modports
//   master : controller / memory side
//   slave  : fetch_unit
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int AW = 13,
   parameter int DW = 8
);
   logic [DW-1:0] data;
   logic          load_ir;
   logic          inc_pc;
   logic          load_pc;
   logic          halt;
   logic          fetch;
   logic [2:0]    opcode;
   logic [AW-1:0] ir_addr;
   logic [AW-1:0] pc_addr;
   logic [AW-1:0] addr;
   logic          ir_valid;
   logic          halted;
   logic          pc_fault;

   modport master (
      output data, load_ir, inc_pc, load_pc, halt, fetch,
      input  opcode, ir_addr, pc_addr, addr, ir_valid, halted, pc_fault
   );

   modport slave (
      input  data, load_ir, inc_pc, load_pc, halt, fetch,
      output opcode, ir_addr, pc_addr, addr, ir_valid, halted, pc_fault
   );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch datapath for the 8-bit-bus RISC CPU. Assembles the 16-bit
// instruction from two bus bytes (high byte first), keeps the program counter,
// and drives the memory address mux (PC side during fetch, operand field of IR
// otherwise). All state updates on the rising edge of clk_ctrl; the controller
// moves its strobes on the falling edge.
//
// Ports
//   clk_ctrl : control clock
//   rst_n    : asynchronous active-low reset
//   bus      : fetch_unit_if.slave (strobes/data in, decodes/address out)
//
// Optional feature (compile-time macro PC_WRAP_FAULT_EN)
//   defined   : an inc_pc at the top PC value sets sticky pc_fault, holds PC
//               and halts; a byte-fetch address pc+byte_sel that overflows
//               sets pc_fault on a load_ir edge without halting.
//   undefined : PC wraps silently, pc_fault is constant 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int AW = 13,
   parameter int DW = 8
) (
   input  logic         clk_ctrl,
   input  logic         rst_n,
   fetch_unit_if.slave  bus
);
   localparam int IW = 2 * DW;

   logic [IW-1:0] ir;
   logic [AW-1:0] pc;
   logic          byte_sel;   // 0 = next load_ir is the high byte
   logic          ir_valid;
   logic          halted;
   logic          pc_fault;

   // strobes only count while the unit is running
   logic          run;
   logic          wrap_halt;  // inc_pc at top of PC range traps instead of wrapping
   logic          fetch_ovf;  // byte address pc+byte_sel rolls past the top

   assign run = !halted;

`ifdef PC_WRAP_FAULT_EN
   logic pc_max;
   assign pc_max    = (pc == {AW{1'b1}});
   // load_pc outranks inc_pc, so a JUMP at the top address is not a fault
   assign wrap_halt = bus.inc_pc && !bus.load_pc && pc_max;
   assign fetch_ovf = bus.load_ir && byte_sel && pc_max;
`else
   assign wrap_halt = 1'b0;
   assign fetch_ovf = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Instruction register byte assembly
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_ctrl or negedge rst_n) begin
      if (!rst_n) begin
         ir       <= '0;
         byte_sel <= 1'b0;
         ir_valid <= 1'b0;
      end else if (run && bus.load_ir) begin
         if (!byte_sel) begin
            ir[IW-1:DW] <= bus.data;
            byte_sel    <= 1'b1;
            ir_valid    <= 1'b0;
         end else begin
            ir[DW-1:0]  <= bus.data;
            byte_sel    <= 1'b0;
            ir_valid    <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Program counter and halt latch
   // halt wins over everything, then load_pc, then inc_pc. load_pc uses the
   // operand field present before this edge, so a same-edge IR capture does
   // not leak into the jump target.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_ctrl or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         halted <= 1'b0;
      end else if (run) begin
         if (bus.halt) begin
            halted <= 1'b1;
         end else if (bus.load_pc) begin
            pc <= ir[AW-1:0];
         end else if (bus.inc_pc) begin
            if (wrap_halt)
               halted <= 1'b1;
            else
               pc <= pc + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Overflow flag
   // ---------------------------------------------------------------------------
`ifdef PC_WRAP_FAULT_EN
   always_ff @(posedge clk_ctrl or negedge rst_n) begin
      if (!rst_n)
         pc_fault <= 1'b0;
      else if (run && ((!bus.halt && wrap_halt) || fetch_ovf))
         pc_fault <= 1'b1;
   end
`else
   assign pc_fault = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.opcode   = ir[IW-1 -: 3];
   assign bus.ir_addr  = ir[AW-1:0];
   assign bus.pc_addr  = pc;
   assign bus.ir_valid = ir_valid;
   assign bus.halted   = halted;
   assign bus.pc_fault = pc_fault;

   // low byte lives at pc+1 while the increment is still in flight
   assign bus.addr = bus.fetch ? (pc + {{(AW-1){1'b0}}, byte_sel}) : ir[AW-1:0];

endmodule
